// File: rtl/crop_seq_pkg.sv
// rtl/crop_seq_pkg.sv - shared types, header offsets and stride helper for the crop pass sequencer
package crop_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR_RD,
      S_HDR_CHK,
      S_SCAN,
      S_CROP_ARM,
      S_CROP,
      S_DONE
   } state_t;

   typedef enum logic [2:0] {
      STAT_OK      = 3'd0,
      STAT_BAD_SIG = 3'd1,
      STAT_BAD_BPP = 3'd2,
      STAT_BAD_DIM = 3'd3,
      STAT_EMPTY   = 3'd4,
      STAT_TIMEOUT = 3'd5
   } status_t;

   localparam int OFS_SIG      = 0;
   localparam int OFS_PIX_BASE = 10;
   localparam int OFS_WIDTH    = 18;
   localparam int OFS_HEIGHT   = 22;
   localparam int OFS_BPP      = 28;
   localparam int HDR_BYTES    = 30;

   // 24bpp row length rounded up to a 4-byte boundary; callers truncate to their address width
   function automatic logic [31:0] padded_stride(input logic [31:0] w);
      return (w * 32'd3 + 32'd3) & ~32'd3;
   endfunction

endpackage

// File: rtl/bmp_hdr_capture.sv
// rtl/bmp_hdr_capture.sv - sequential BMP header reader and field capture
import crop_seq_pkg::*;

module bmp_hdr_capture #(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              go,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [7:0]        rd_data,
   output logic [15:0]       sig,
   output logic [31:0]       pix_base,
   output logic [31:0]       width,
   output logic [31:0]       height,
   output logic [15:0]       bpp,
   output logic              last,
   output logic              valid
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(HDR_BYTES - 1);

   logic       cap_en;
   logic [4:0] cap_addr;

   // the final header byte is being captured this cycle; every field is complete next cycle
   assign last = cap_en && (cap_addr == 5'(HDR_BYTES - 1));

   // read address generator: one byte per cycle from 0 to HDR_BYTES-1
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_en   <= 1'b0;
         rd_addr <= '0;
      end else if (go) begin
         rd_en   <= 1'b1;
         rd_addr <= '0;
      end else if (rd_en) begin
         if (rd_addr == LAST_ADDR) rd_en <= 1'b0;
         else rd_addr <= rd_addr + ADDR_W'(1);
      end
   end

   // memory returns data one cycle after the address, so track which byte is arriving
   always_ff @(posedge clk) begin
      if (reset) begin
         cap_en   <= 1'b0;
         cap_addr <= '0;
      end else begin
         cap_en   <= rd_en;
         cap_addr <= rd_addr[4:0];
      end
   end

   // steer each arriving little-endian byte into its field
   always_ff @(posedge clk) begin
      if (reset) begin
         sig      <= '0;
         pix_base <= '0;
         width    <= '0;
         height   <= '0;
         bpp      <= '0;
      end else if (cap_en) begin
         case (cap_addr)
            5'(OFS_SIG):          sig[7:0]        <= rd_data;
            5'(OFS_SIG + 1):      sig[15:8]       <= rd_data;
            5'(OFS_PIX_BASE):     pix_base[7:0]   <= rd_data;
            5'(OFS_PIX_BASE + 1): pix_base[15:8]  <= rd_data;
            5'(OFS_PIX_BASE + 2): pix_base[23:16] <= rd_data;
            5'(OFS_PIX_BASE + 3): pix_base[31:24] <= rd_data;
            5'(OFS_WIDTH):        width[7:0]      <= rd_data;
            5'(OFS_WIDTH + 1):    width[15:8]     <= rd_data;
            5'(OFS_WIDTH + 2):    width[23:16]    <= rd_data;
            5'(OFS_WIDTH + 3):    width[31:24]    <= rd_data;
            5'(OFS_HEIGHT):       height[7:0]     <= rd_data;
            5'(OFS_HEIGHT + 1):   height[15:8]    <= rd_data;
            5'(OFS_HEIGHT + 2):   height[23:16]   <= rd_data;
            5'(OFS_HEIGHT + 3):   height[31:24]   <= rd_data;
            5'(OFS_BPP):          bpp[7:0]        <= rd_data;
            5'(OFS_BPP + 1):      bpp[15:8]       <= rd_data;
            default: ;
         endcase
      end
   end

   // fields-complete flag, cleared whenever a new read sequence begins
   always_ff @(posedge clk) begin
      if (reset || go) valid <= 1'b0;
      else if (last) valid <= 1'b1;
   end

endmodule

// File: rtl/crop_pass_sequencer.sv
// rtl/crop_pass_sequencer.sv - BMP crop pass controller; optional engine watchdog via CROP_SEQ_WATCHDOG_EN
import crop_seq_pkg::*;

module crop_pass_sequencer #(
   parameter int ADDR_W      = 16,
   parameter int DIM_W       = 12,
   parameter int MAX_DIM     = 2048,
   parameter int WDOG_CYCLES = 2**20
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [2:0]        status,
   output logic              hdr_rd_en,
   output logic [ADDR_W-1:0] hdr_rd_addr,
   input  logic [7:0]        hdr_rd_data,
   output logic [DIM_W-1:0]  img_width,
   output logic [DIM_W-1:0]  img_height,
   output logic [ADDR_W-1:0] row_stride,
   output logic [ADDR_W-1:0] pix_base,
   output logic              scan_start,
   input  logic              scan_done,
   input  logic [DIM_W-1:0]  bbox_x0,
   input  logic [DIM_W-1:0]  bbox_y0,
   input  logic [DIM_W-1:0]  bbox_x1,
   input  logic [DIM_W-1:0]  bbox_y1,
   input  logic              bbox_empty,
   output logic              crop_start,
   input  logic              crop_done,
   output logic [DIM_W-1:0]  crop_width,
   output logic [DIM_W-1:0]  crop_height,
   output logic [ADDR_W-1:0] crop_stride
);

   state_t      state, next_state;
   status_t     next_code, hdr_code;
   logic        accept, hdr_last, hdr_valid, bbox_bad, wdog_hit;
   logic [15:0] hdr_sig, hdr_bpp;
   logic [31:0] hdr_pix_base, hdr_width, hdr_height;

   bmp_hdr_capture #(.ADDR_W(ADDR_W)) u_hdr (
      .clk      (CLOCK_50),
      .reset    (reset),
      .go       (accept),
      .rd_en    (hdr_rd_en),
      .rd_addr  (hdr_rd_addr),
      .rd_data  (hdr_rd_data),
      .sig      (hdr_sig),
      .pix_base (hdr_pix_base),
      .width    (hdr_width),
      .height   (hdr_height),
      .bpp      (hdr_bpp),
      .last     (hdr_last),
      .valid    (hdr_valid)
   );

   assign accept   = start && (state == S_IDLE || state == S_DONE);
   assign bbox_bad = (bbox_x1 < bbox_x0) || (bbox_y1 < bbox_y0) ||
                     (bbox_x1 >= img_width) || (bbox_y1 >= img_height);

   // header validation; the first failing check decides the code
   always_comb begin
      hdr_code = STAT_OK;
      if (hdr_sig != 16'h4D42)
         hdr_code = STAT_BAD_SIG;
      else if (hdr_bpp != 16'd24)
         hdr_code = STAT_BAD_BPP;
      else if (hdr_width == 32'd0 || hdr_width > 32'(MAX_DIM) ||
               hdr_height == 32'd0 || hdr_height[31] || hdr_height > 32'(MAX_DIM))
         hdr_code = STAT_BAD_DIM;
   end

`ifdef CROP_SEQ_WATCHDOG_EN
   localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
   logic [WDOG_W-1:0] wdog_cnt;

   // per-pass engine timer, restarted on every state change
   always_ff @(posedge CLOCK_50) begin
      if (reset || next_state != state) wdog_cnt <= '0;
      else if (state == S_SCAN || state == S_CROP) wdog_cnt <= wdog_cnt + WDOG_W'(1);
   end

   assign wdog_hit = (state == S_SCAN || state == S_CROP) && (wdog_cnt == WDOG_W'(WDOG_CYCLES));
`else
   assign wdog_hit = 1'b0;
`endif

   // state register
   always_ff @(posedge CLOCK_50) begin
      if (reset) state <= S_IDLE;
      else state <= next_state;
   end

   // next state plus the status code to publish when entering DONE
   always_comb begin
      next_state = state;
      next_code  = STAT_OK;
      case (state)
         S_IDLE, S_DONE: if (start) next_state = S_HDR_RD;
         S_HDR_RD:       if (hdr_last) next_state = S_HDR_CHK;
         S_HDR_CHK: begin
            if (hdr_valid) begin
               if (hdr_code != STAT_OK) begin
                  next_state = S_DONE;
                  next_code  = hdr_code;
               end else begin
                  next_state = S_SCAN;
               end
            end
         end
         S_SCAN: begin
            if (scan_done) begin
               if (bbox_empty) begin
                  next_state = S_DONE;
                  next_code  = STAT_EMPTY;
               end else if (bbox_bad) begin
                  next_state = S_DONE;
                  next_code  = STAT_BAD_DIM;
               end else begin
                  next_state = S_CROP_ARM;
               end
            end else if (wdog_hit) begin
               next_state = S_DONE;
               next_code  = STAT_TIMEOUT;
            end
         end
         S_CROP_ARM: next_state = S_CROP;
         S_CROP: begin
            if (crop_done) begin
               next_state = S_DONE;
            end else if (wdog_hit) begin
               next_state = S_DONE;
               next_code  = STAT_TIMEOUT;
            end
         end
         default: next_state = S_IDLE;
      endcase
   end

   // registered outputs: handshake, status and geometry publication
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         busy        <= 1'b0;
         done        <= 1'b0;
         status      <= '0;
         scan_start  <= 1'b0;
         crop_start  <= 1'b0;
         img_width   <= '0;
         img_height  <= '0;
         row_stride  <= '0;
         pix_base    <= '0;
         crop_width  <= '0;
         crop_height <= '0;
         crop_stride <= '0;
      end else begin
         scan_start <= (state == S_HDR_CHK) && (next_state == S_SCAN);
         crop_start <= (state == S_CROP_ARM);
         if (accept) begin
            busy   <= 1'b1;
            done   <= 1'b0;
            status <= '0;
         end else if (state != S_DONE && next_state == S_DONE) begin
            busy   <= 1'b0;
            done   <= 1'b1;
            status <= next_code;
         end
         if (state == S_HDR_CHK && next_state == S_SCAN) begin
            img_width  <= DIM_W'(hdr_width);
            img_height <= DIM_W'(hdr_height);
            row_stride <= ADDR_W'(padded_stride(hdr_width));
            pix_base   <= ADDR_W'(hdr_pix_base);
         end
         if (state == S_SCAN && next_state == S_CROP_ARM) begin
            crop_width  <= bbox_x1 - bbox_x0 + DIM_W'(1);
            crop_height <= bbox_y1 - bbox_y0 + DIM_W'(1);
         end
         if (state == S_CROP_ARM)
            crop_stride <= ADDR_W'(padded_stride(32'(crop_width)));
      end
   end

endmodule

// File: doc/crop_pass_sequencer.md
# crop_pass_sequencer

Top-level controller for the BMP cropping pipeline. It reads and validates the 24-bit BMP header from the input image memory, then publishes the image geometry. It runs the bounding-box scan engine, converts the returned box into crop geometry and runs the crop/write engine. It reports completion and status through one `done`/`status` pair, which the bench polls.

## Interface
- `ADDR_W`, 16: byte address width of the input image memory.
- `DIM_W`, 12: width of every pixel dimension and coordinate.
- `MAX_DIM`, 2048: largest legal width or height.
- `WDOG_CYCLES`, 2**20: watchdog limit per engine pass. Used only when the watchdog is compiled in.
- `CLOCK_50` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: single-cycle request to begin processing.
- `busy` out 1: high from the cycle after `start` is accepted until `done` rises.
- `done` out 1: level; stays high until the next `start` is accepted.
- `status` out 3: result code, 0 OK, 1 BAD_SIG, 2 BAD_BPP, 3 BAD_DIM, 4 EMPTY, 5 TIMEOUT.
- `hdr_rd_en` out 1: header read strobe.
- `hdr_rd_addr` out ADDR_W: header byte address.
- `hdr_rd_data` in 8: header read data, valid 1 cycle after the address.
- `img_width`, `img_height` out DIM_W: image dimensions from the header.
- `row_stride` out ADDR_W: padded input row length in bytes.
- `pix_base` out ADDR_W: pixel data offset from the header.
- `scan_start` out 1: 1-cycle pulse that starts the scan engine.
- `scan_done` in 1: 1-cycle pulse from the scan engine.
- `bbox_x0`, `bbox_y0`, `bbox_x1`, `bbox_y1` in DIM_W: bounding box corners. Sampled on the `scan_done` cycle.
- `bbox_empty` in 1: no foreground found. Sampled on the `scan_done` cycle.
- `crop_start` out 1: 1-cycle pulse that starts the crop engine.
- `crop_done` in 1: 1-cycle pulse from the crop engine.
- `crop_width`, `crop_height` out DIM_W: crop dimensions.
- `crop_stride` out ADDR_W: padded output row length in bytes.

## Operation
- States, in order: IDLE, HDR_RD, HDR_CHK, SCAN, CROP_ARM, CROP, DONE.
- `start` is honoured only in IDLE or DONE. Accepting it clears `done` and resets `status` to 0. `start` is ignored in every other state.
- HDR_RD issues reads of byte addresses 0..29, one per cycle, and captures the fields it needs:
  - signature from bytes 0–1;
  - `pix_base` from bytes 10–13;
  - width from bytes 18–21;
  - height from bytes 22–25;
  - bits per pixel from bytes 28–29.
  - All multi-byte fields are little-endian.
- HDR_CHK checks the fields in this priority order:
  - signature ≠ "BM" (0x42, 0x4D) gives BAD_SIG;
  - bits per pixel ≠ 24 gives BAD_BPP;
  - width or height is 0, exceeds MAX_DIM, or has height bit 31 set (top-down image) gives BAD_DIM.
  - Any failure goes straight to DONE.
- Stride arithmetic: `row_stride` = (w·3 + 3) & ~3, computed at ADDR_W width. `crop_stride` uses the same formula on `crop_width`.
- On `scan_done` in SCAN:
  - `bbox_empty` gives EMPTY and goes to DONE;
  - x1 < x0, y1 < y0, x1 ≥ width or y1 ≥ height gives BAD_DIM and goes to DONE;
  - otherwise go to CROP_ARM with `crop_width` = x1−x0+1 and `crop_height` = y1−y0+1.
- `crop_done` in CROP gives status OK and goes to DONE.
- `scan_done` and `crop_done` arriving in any other state are ignored.
- Geometry outputs hold their values from the last run until the next accepted `start`.

## Timing
- All outputs are registered. On reset, every output is 0 and the state is IDLE, including reset asserted mid-run.
- With `start` sampled at edge 0:
  - `hdr_rd_en` is high in cycles 1–30 with address 0..29;
  - the data for address 29 arrives in cycle 31;
  - HDR_CHK occupies cycle 32;
  - `scan_start` is high in cycle 33 on a valid header;
  - on a header failure, `done` is high from cycle 33 instead.
- `scan_done` sampled at edge e: CROP_ARM at e+1, `crop_start` high at e+2.
- `crop_done` sampled at edge f: `done` high and `busy` low from f+1.
- The geometry outputs are stable before the start pulse of the engine that uses them.

## Configuration
- Macro: `CROP_SEQ_WATCHDOG_EN`.
- When defined: a counter runs in SCAN and in CROP and resets at each state entry. When it reaches WDOG_CYCLES, status becomes TIMEOUT and the state moves to DONE on the next cycle. A done pulse arriving on that same cycle takes precedence over the timeout.
- When undefined: SCAN and CROP wait indefinitely and WDOG_CYCLES is unused.

## Structure
- Package `crop_seq_pkg` holds:
  - the state enum and the status enum;
  - the header offset constants (0, 10, 18, 22, 28) and HDR_BYTES = 30;
  - a `padded_stride` function.
- Sub-module `bmp_hdr_capture` holds the HDR_RD address counter and the field capture registers. It takes a go input and returns the captured fields with a valid flag.

## Test plan
- Valid header, 40×30, pix_base 54 → `img_width` = 40, `row_stride` = 120, `scan_start` exactly at cycle 33.
- Width 41 → `row_stride` = 124. Bbox (5,10)-(24,19) → `crop_width` = 20, `crop_height` = 10, `crop_stride` = 60. `crop_start` 2 cycles after `scan_done`. After `crop_done`: status 0, `done` high.
- bpp = 8 → status 2 and `done` at cycle 33 with no `scan_start`. Signature "XM" → status 1.
- `bbox_empty` on `scan_done` → status 4 with no `crop_start`. Bbox x1 = 40 on a 40-wide image → status 3.
- `start` asserted during SCAN is ignored. `reset` during CROP → all outputs 0 next cycle. A fresh `start` afterwards completes normally.
- With `CROP_SEQ_WATCHDOG_EN` and WDOG_CYCLES = 100, `scan_done` never asserted → status 5 and `done` high 101 cycles after `scan_start`.
